// File: rtl/shift_mult_sched.sv
// Round-robin scheduler sharing one iterative shift-and-add W x W multiplier
// among NREQ requesters; results return tagged with the owner's index.
module shift_mult_sched #(
    parameter  int W    = 16,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_product,
    output logic                busy
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2*W-1:0]   r_a;
    logic [W-1:0]     r_b;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_last_grant;
    logic [2*W-1:0]   r_product;
    logic [IDW-1:0]   r_rsp_id;

    logic             w_any;
    logic [IDW-1:0]   w_grant;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic [2*W-1:0]   w_acc_next;
    logic             w_last_iter;

    // Round-robin: the valid requester at the smallest distance past last_grant wins.
    always_comb begin
        int d;
        int best_d;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        d       = 0;
        best_d  = NREQ;
        w_grant = '0;
        w_any   = |req_valid;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - 1 - int'(r_last_grant)) % NREQ;
            if (req_valid[i] && d < best_d) begin
                best_d  = d;
                w_grant = IDW'(i);
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
            end
        end
        if (r_state == S_IDLE && w_any) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_acc_next  = r_acc + (r_b[0] ? r_a : '0);
    assign w_last_iter = (r_cnt == CW'(W - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any)       w_next = S_MUL;
            S_MUL:   if (w_last_iter) w_next = S_RESP;
            S_RESP:  if (rsp_ready)   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every datapath register is reset: the arbitration pointer must restart at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_id         <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_product    <= '0;
            r_rsp_id     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a          <= {{W{1'b0}}, w_sel_a};
                        r_b          <= w_sel_b;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last_iter) begin
                        r_product <= w_acc_next;
                        r_rsp_id  <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_product;

endmodule

// File: doc/shift_mult_sched.md
Name: shift_mult_sched

Overview:
Round-robin scheduler that shares one iterative shift-and-add 16x16 multiplier among NREQ requesters. It contains the multiplier datapath and the FSM that sequences it, one left-shift/add iteration per clock. Each requester presents operands with a valid/ready handshake. Results return on a single response channel tagged with the requester id, with backpressure.

Parameters:
W, 16, operand width; product is 2*W bits
NREQ, 4, number of requesters (>=2); IDW = $clog2(NREQ) is a derived localparam

Ports:
clk  input  1  clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester accept, at most one bit high
req_a  input  NREQ*W  multiplicands, requester i in bits [i*W +: W]
req_b  input  NREQ*W  multipliers, same packing
rsp_valid  output  1  product available
rsp_ready  input  1  consumer accepts product
rsp_id  output  IDW  index of the requester that owns the product
rsp_product  output  2*W  unsigned product a*b
busy  output  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0, req_ready=0, last_grant=NREQ-1 (requester 0 wins first), accumulator and counter 0.
- FSM states: IDLE, MUL, RESP.
- IDLE, arbitration:
  - If any req_valid is high, grant g = first valid index searching from last_grant+1 with wrap-around (round-robin).
  - req_ready[g] is driven combinationally high in the same cycle; the handshake completes on that edge.
  - On that edge: a_reg = zero-extended req_a[g] (2*W bits), b_reg = req_b[g], acc = 0, cnt = 0, id_reg = g, last_grant = g, then go to MUL.
  - If no req_valid, stay in IDLE.
- req_ready timing: all bits are 0 outside IDLE.
- Requester protocol: a requester holds valid and operands stable until ready. The block does not check this.
- MUL, one iteration per edge:
  - if b_reg[0] then acc = acc + a_reg;
  - a_reg = a_reg << 1; b_reg = b_reg >> 1; cnt = cnt + 1.
  - The edge on which cnt reaches W-1 performs the last iteration, then the state goes to RESP with rsp_product = final acc and rsp_id = id_reg.
- Latency: fixed, no early termination. Always exactly W iterations, including zero operands.
- Latency timing: rsp_valid rises after exactly W+1 posedges counted from (and including) the accepting edge.
- Arithmetic: 2*W-bit accumulator with no overflow possible. Result equals the unsigned a*b exactly; max 0xFFFF*0xFFFF = 0xFFFE0001.
- RESP:
  - rsp_valid=1; rsp_product and rsp_id are held stable until rsp_ready=1.
  - On the edge where rsp_valid && rsp_ready, go to IDLE and clear rsp_valid.
  - No new grant occurs in that same cycle; the earliest next accept is the following cycle.
  - Minimum issue interval is W+2 cycles.
- Backpressure: while in RESP with rsp_ready=0, no req_ready is asserted and all requests wait.
- Simultaneous requests: only one grant per IDLE cycle. A requester that just won has the lowest priority next round.
- Reset mid-operation: any in-flight multiply or pending response is discarded with no response emitted. Arbitration pointer restarts at requester 0.
- Idle outputs: rsp_product and rsp_id keep their last values while idle; they are valid only while rsp_valid=1.

Test Plan:
- Single request: req_valid[0]=1, a=3, b=5, rsp_ready=1 -> req_ready[0] pulses 1 cycle; rsp_valid after 17 posedges (W+1) with rsp_product=15, rsp_id=0; busy high from the edge after accept through the RESP cycle.
- Max operands: req 2, a=0xFFFF, b=0xFFFF -> rsp_product=0xFFFE0001, rsp_id=2; zero case a=0, b=0x1234 -> rsp_product=0 at the same latency.
- Fairness: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; consecutive accepts 18 cycles apart (W+2).
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_product and rsp_id stable; no req_ready asserted; release -> IDLE next cycle, next grant one cycle later.
- Reset mid-MUL: drop rst_n at iteration 8 -> rsp_valid=0, busy=0 immediately; after release with req 1 and req 3 valid, req 1 is granted first (pointer reset).
- Random regression: 200 random operand pairs on random requesters with random rsp_ready stalls -> every rsp_product equals the a*b model, rsp_id matches the issuing requester, no lost or duplicated responses.
